// File: rtl/output_ram_ctrl_pkg.sv
// Shared definitions for the output RAM write sequencer and its neighbours.
package output_ram_ctrl_pkg;

  // Widths shared with output_ram.
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } state_t;

endpackage : output_ram_ctrl_pkg

// File: rtl/output_ram_ctrl_if.sv
// Producer handshake, RAM write port and status signals of the output RAM sequencer.
interface output_ram_ctrl_if
  import output_ram_ctrl_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned AW = ADDR_W
);

  // Frame control from the top-level controller.
  logic          start;
  logic          flush;

  // Result stream from the datapath.
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  // Write port towards output_ram.
  logic          ram_write_en;
  logic [AW-1:0] ram_write_address;
  logic [DW-1:0] ram_input_data;
  logic          ram_write_file;

  // Status back to the controller.
  logic          busy;
  logic          done;
  logic [AW:0]   rows_written;

  // Environment side: drives control and data, observes everything else.
  modport master (
    output start, flush, in_valid, in_data,
    input  in_ready, ram_write_en, ram_write_address, ram_input_data,
    input  ram_write_file, busy, done, rows_written
  );

  // Sequencer side.
  modport slave (
    input  start, flush, in_valid, in_data,
    output in_ready, ram_write_en, ram_write_address, ram_input_data,
    output ram_write_file, busy, done, rows_written
  );

endinterface : output_ram_ctrl_if

// File: rtl/output_ram_ctrl.sv
// Collects one frame of results into output_ram at addresses 0..DEPTH-1,
// then pulses write_file once after the last row has been committed.
module output_ram_ctrl
  import output_ram_ctrl_pkg::*;
#(
  parameter int unsigned P_DATA_W = DATA_W,
  parameter int unsigned P_ADDR_W = ADDR_W,
  parameter int unsigned P_DEPTH  = 2 ** P_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output_ram_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = P_ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(P_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(P_DEPTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             accept;

  // Room is left only while filling and the frame is not yet full.
  assign bus.in_ready = (state == FILL) && (count < DEPTH_C);
  assign accept       = bus.in_ready && bus.in_valid;

  // Saturating row counter step; the address therefore never wraps in a frame.
  assign count_inc = (count < DEPTH_C) ? CNT_W'(count + 1'b1) : count;

  // Frame sequencer with registered RAM port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      count                 <= '0;
      bus.ram_write_en      <= 1'b0;
      bus.ram_write_address <= '0;
      bus.ram_input_data    <= '0;
      bus.ram_write_file    <= 1'b0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.rows_written      <= '0;
    end else begin
      bus.ram_write_en   <= 1'b0;
      bus.ram_write_file <= 1'b0;
      bus.done           <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state            <= FILL;
            count            <= '0;
            bus.rows_written <= '0;
            bus.busy         <= 1'b1;
          end
        end

        FILL: begin
          // An accept in the same cycle as flush is still written.
          if (accept) begin
            bus.ram_write_en      <= 1'b1;
            bus.ram_write_address <= count[P_ADDR_W-1:0];
            bus.ram_input_data    <= bus.in_data;
            count                 <= count_inc;
            bus.rows_written      <= count_inc;
          end
          if (bus.flush || (accept && (count == LAST_C))) begin
            state <= DRAIN;
          end
        end

        // Let the final RAM write commit before asking for the file dump.
        DRAIN: begin
          bus.ram_write_file <= 1'b1;
          state              <= DUMP;
        end

        DUMP: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : output_ram_ctrl

// File: tb/tb_output_ram_ctrl.sv
// Randomised scoreboard bench for output_ram_ctrl.
module tb_output_ram_ctrl;
  import output_ram_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int           cyc;
    logic [255:0] img;
  } file_t;

  typedef struct {
    int cyc;
    int rows;
  } done_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t   exp_wr[$];
  file_t exp_file[$];
  done_t exp_done[$];

  // Reference model of a frame: whether a frame is open, rows taken, RAM image.
  bit          m_open = 0;
  int          m_cnt = 0;
  int          m_idle_from = 0;
  logic [31:0] ref_ram [8];
  logic [31:0] mon_ram [8];

  output_ram_ctrl_if bus ();

  output_ram_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [255:0] pack_ref();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = ref_ram[i];
    return r;
  endfunction

  function automatic logic [255:0] pack_mon();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = mon_ram[i];
    return r;
  endfunction

  // Monitor: plays the role of output_ram and checks every presented event.
  wr_t   mw;
  file_t mf;
  done_t md;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_write_en) begin
        if (exp_wr.size() == 0) unexpected("ram_write_en");
        else begin
          mw = exp_wr.pop_front();
          chk("wr_cycle", 256'(cyc), 256'(mw.cyc));
          chk("wr_addr", 256'(bus.ram_write_address), 256'(mw.addr));
          chk("wr_data", 256'(bus.ram_input_data), 256'(mw.data));
        end
        mon_ram[bus.ram_write_address] = bus.ram_input_data;
      end
      if (bus.ram_write_file) begin
        if (exp_file.size() == 0) unexpected("ram_write_file");
        else begin
          mf = exp_file.pop_front();
          chk("file_cycle", 256'(cyc), 256'(mf.cyc));
          chk("file_image", pack_mon(), mf.img);
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) unexpected("done");
        else begin
          md = exp_done.pop_front();
          chk("done_cycle", 256'(cyc), 256'(md.cyc));
          chk("rows_written", 256'(bus.rows_written), 256'(md.rows));
        end
      end
    end
  end

  // One clock cycle of stimulus; the model predicts the effect of the coming edge.
  task automatic step(input bit st, input bit fl, input bit vl, input logic [31:0] d);
    int e;
    bit idle;
    @(posedge clk);
    #1;
    bus.start    = st;
    bus.flush    = fl;
    bus.in_valid = vl;
    bus.in_data  = d;
    #1;
    e    = cyc + 1;
    idle = !m_open && (e >= m_idle_from);
    chk("in_ready", 256'(bus.in_ready), 256'(m_open && (m_cnt < 8)));
    chk("busy", 256'(bus.busy), 256'(!idle));
    if (idle) begin
      if (st) begin
        m_open = 1;
        m_cnt  = 0;
      end
    end else if (m_open) begin
      if (vl && (m_cnt < 8)) begin
        exp_wr.push_back('{e, 3'(m_cnt), d});
        ref_ram[m_cnt] = d;
        m_cnt++;
      end
      if (fl || (m_cnt == 8)) begin
        exp_file.push_back('{e + 1, pack_ref()});
        exp_done.push_back('{e + 2, m_cnt});
        m_open      = 0;
        m_idle_from = e + 3;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write_en"}, 256'(bus.ram_write_en), 256'(0));
    chk({tag, "_address"}, 256'(bus.ram_write_address), 256'(0));
    chk({tag, "_data"}, 256'(bus.ram_input_data), 256'(0));
    chk({tag, "_write_file"}, 256'(bus.ram_write_file), 256'(0));
    chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
    chk({tag, "_done"}, 256'(bus.done), 256'(0));
    chk({tag, "_rows"}, 256'(bus.rows_written), 256'(0));
    chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'(0));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    chk("pending_wr_at_rst", 256'(exp_wr.size()), 256'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_open      = 0;
    m_cnt       = 0;
    m_idle_from = 0;
    exp_file.delete();
    exp_done.delete();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref_ram[i] = '0;
      mon_ram[i] = '0;
    end
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #1;
    rst = 1'b0;
    idle_steps(2);

    // Full frame with back-to-back valid.
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h1000_0000 + 32'(i));
    idle_steps(4);

    // Stalled producer: valid once every three cycles.
    step(1, 0, 0, 32'h0);
    for (int j = 0; j < 40 && m_open; j++) step(0, 0, (j % 3) == 0, $urandom);
    idle_steps(4);

    // Early flush together with a fourth row.
    step(1, 0, 0, 32'h0);
    step(0, 0, 1, 32'hA);
    step(0, 0, 1, 32'hB);
    step(0, 0, 1, 32'hC);
    step(0, 1, 1, 32'hD);
    idle_steps(4);

    // Ignored inputs: valid and flush in IDLE, start in FILL.
    step(0, 0, 1, 32'hDEAD_0001);
    step(0, 1, 1, 32'hDEAD_0002);
    step(1, 0, 0, 32'h0);
    step(0, 0, 1, 32'h2000_0000);
    step(1, 0, 1, 32'h2000_0001);
    step(0, 0, 1, 32'h2000_0002);
    step(0, 1, 0, 32'h0);
    idle_steps(4);

    // Reset after row 5, then a fresh frame restarting at address 0.
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h3000_0000 + 32'(i));
    step(0, 0, 0, 32'h0);
    reset_mid();
    idle_steps(3);
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h4000_0000 + 32'(i));
    idle_steps(4);

    // Zero-row flush.
    step(1, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    idle_steps(4);

    // Random traffic, including back-to-back frames and stray control.
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 2), ($urandom % 10) == 0, ($urandom % 4) != 0, $urandom);
    idle_steps(6);

    for (int i = 0; i < 20 && (exp_wr.size() + exp_file.size() + exp_done.size()) > 0; i++)
      @(posedge clk);
    chk("pending_writes", 256'(exp_wr.size()), 256'(0));
    chk("pending_files", 256'(exp_file.size()), 256'(0));
    chk("pending_dones", 256'(exp_done.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_output_ram_ctrl
